// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg -- shared types, default geometry and address-split helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int OFFSET_W       = $clog2(DEF_LINE_WORDS);
    localparam int INDEX_W        = $clog2(DEF_LINES);
    localparam int TAG_W          = 32 - 2 - OFFSET_W - INDEX_W;

    typedef enum logic [2:0] {
        ST_LOOKUP      = 3'd0,
        ST_WRITE_REQ   = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_DATA = 3'd3,
        ST_REFILL_DONE = 3'd4
    } state_t;

    // Helpers take the widths as arguments so any legal geometry can use them.
    function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int off_w,
                                               input int idx_w);
        return (a >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w,
                                             input int idx_w);
        return a >> (2 + off_w + idx_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_data_ram.sv
// ============================================================================
// dcache_data_ram -- 32-bit synchronous RAM, byte write enables, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    we,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Same-address read and write return the freshly written bytes.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
            if (we[b] && (waddr == raddr)) begin
                rdata[b*8 +: 8] <= wdata[b*8 +: 8];
            end else begin
                rdata[b*8 +: 8] <= mem[raddr][b*8 +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_direct_mapped.sv
// ============================================================================
// dcache_direct_mapped -- blocking direct-mapped write-through data cache
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_direct_mapped
    import cache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rnw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = 32 - 2 - OFF_BITS - IDX_BITS;
    localparam int RAM_AW   = IDX_BITS + OFF_BITS;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    state_t state, state_nxt;

    logic                req_valid;
    logic                req_is_wr;
    logic [29:0]         req_waddr;
    logic [3:0]          req_we;
    logic [31:0]         req_din;
    logic [31:0]         req_addr;
    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] req_idx;
    logic [OFF_BITS-1:0] req_word;

    logic [LINES-1:0]    valid_bits;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic                hit;

    logic [OFF_BITS-1:0] beat;
    logic [31:0]         fill_word;
    logic [31:0]         dout_q;
    logic [31:0]         dout_nxt;

    logic                cpu_req;
    logic                accept;
    logic [1:0]          unused_addr_bits;

    logic [RAM_AW-1:0]   ram_raddr;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [31:0]         ram_wdata;
    logic [3:0]          ram_we;
    logic [31:0]         ram_rdata;

    assign unused_addr_bits = cpu_addr[1:0];

    assign req_addr = {req_waddr, 2'b00};
    assign req_tag  = TAG_BITS'(addr_tag(req_addr, OFF_BITS, IDX_BITS));
    assign req_idx  = IDX_BITS'(addr_index(req_addr, OFF_BITS, IDX_BITS));
    assign req_word = OFF_BITS'(addr_word(req_addr, OFF_BITS));
    assign hit      = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

    assign cpu_req  = cpu_re || (cpu_we != 4'b0000);
    assign accept   = !stall && cpu_req;

    // The RAM is addressed straight from the CPU so a hit is ready next cycle.
    assign ram_raddr = {IDX_BITS'(addr_index(cpu_addr, OFF_BITS, IDX_BITS)),
                        OFF_BITS'(addr_word(cpu_addr, OFF_BITS))};

    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rnw   = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_wdata = 32'd0;
        mem_req_wmask = 4'b0000;
        dout_nxt      = dout_q;
        ram_we        = 4'b0000;
        ram_waddr     = {req_idx, req_word};
        ram_wdata     = req_din;

        case (state)
            ST_LOOKUP: begin
                if (req_valid) begin
                    if (req_is_wr) begin
                        mem_req_valid = 1'b1;
                        mem_req_addr  = req_addr;
                        mem_req_wdata = req_din;
                        mem_req_wmask = req_we;
                        ram_we        = hit ? req_we : 4'b0000;
                        if (!mem_req_ready) begin
                            stall     = 1'b1;
                            state_nxt = ST_WRITE_REQ;
                        end
                    end else if (hit) begin
                        dout_nxt = ram_rdata;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_REFILL_REQ;
                    end
                end
            end
            ST_WRITE_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = req_addr;
                mem_req_wdata = req_din;
                mem_req_wmask = req_we;
                stall         = !mem_req_ready;
                if (mem_req_ready) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rnw   = 1'b1;
                mem_req_addr  = {req_addr[31:OFF_BITS+2], {(OFF_BITS+2){1'b0}}};
                stall         = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = ST_REFILL_DATA;
                end
            end
            ST_REFILL_DATA: begin
                stall = 1'b1;
                if (mem_rdata_valid) begin
                    ram_we    = 4'b1111;
                    ram_waddr = {req_idx, beat};
                    ram_wdata = mem_rdata;
                    if (beat == LAST_BEAT) begin
                        state_nxt = ST_REFILL_DONE;
                    end
                end
            end
            ST_REFILL_DONE: begin
                dout_nxt  = fill_word;
                state_nxt = ST_LOOKUP;
            end
            default: begin
                state_nxt = ST_LOOKUP;
            end
        endcase
    end

    assign cpu_dout = dout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOOKUP;
            req_valid  <= 1'b0;
            req_is_wr  <= 1'b0;
            req_waddr  <= 30'd0;
            req_we     <= 4'b0000;
            req_din    <= 32'd0;
            valid_bits <= '0;
            beat       <= '0;
            fill_word  <= 32'd0;
            dout_q     <= 32'd0;
        end else begin
            state  <= state_nxt;
            dout_q <= dout_nxt;
            if (!stall) begin
                req_valid <= accept;
                if (accept) begin
                    req_is_wr <= (cpu_we != 4'b0000);
                    req_waddr <= cpu_addr[31:2];
                    req_we    <= cpu_we;
                    req_din   <= cpu_din;
                end
            end
            // The line being replaced is invalid until its last beat lands.
            if (state == ST_REFILL_REQ) begin
                beat                <= '0;
                valid_bits[req_idx] <= 1'b0;
            end
            if ((state == ST_REFILL_DATA) && mem_rdata_valid) begin
                beat <= beat + 1'b1;
                if (beat == req_word) begin
                    fill_word <= mem_rdata;
                end
                if (beat == LAST_BEAT) begin
                    valid_bits[req_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_REFILL_DATA) && mem_rdata_valid && (beat == LAST_BEAT)) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

    dcache_data_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .we    (ram_we),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
// ============================================================================
// tb_dcache_direct_mapped -- directed bench with a behavioural memory backend
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dcache_direct_mapped;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rnw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    int n_pass  = 0;
    int n_total = 0;

    // Backend state: memory contents default to the word's own address.
    logic [31:0] bmem [int];
    int          hold_cycles = 0;
    int          wait_cnt    = 0;
    int          beats_left  = 0;
    int          beat_idx    = 0;
    logic [31:0] line_base   = 32'd0;
    int          n_reads     = 0;
    int          n_writes    = 0;
    logic [31:0] last_raddr  = 32'd0;

    always #5 clk = ~clk;

    dcache_direct_mapped #(
        .LINES      (64),
        .LINE_WORDS (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_addr        (cpu_addr),
        .cpu_re          (cpu_re),
        .cpu_we          (cpu_we),
        .cpu_din         (cpu_din),
        .cpu_dout        (cpu_dout),
        .stall           (stall),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_rnw     (mem_req_rnw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wmask   (mem_req_wmask),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return bmem.exists(int'(a)) ? bmem[int'(a)] : a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        mem_rdata_valid = 1'b0;
        mem_req_ready   = 1'b0;
        if (rst) begin
            beats_left = 0;
            wait_cnt   = 0;
        end else if (beats_left > 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = word_of(line_base + 32'(beat_idx * 4));
            beat_idx++;
            beats_left--;
        end else if (mem_req_valid) begin
            if (wait_cnt < hold_cycles) begin
                wait_cnt++;
            end else begin
                mem_req_ready = 1'b1;
                wait_cnt      = 0;
                if (mem_req_rnw) begin
                    n_reads++;
                    last_raddr = mem_req_addr;
                    line_base  = mem_req_addr;
                    beats_left = 4;
                    beat_idx   = 0;
                end else begin
                    logic [31:0] w;
                    w = word_of(mem_req_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_req_wmask[b]) w[b*8 +: 8] = mem_req_wdata[b*8 +: 8];
                    bmem[int'(mem_req_addr)] = w;
                    n_writes++;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp,
                            input bit exp_miss, input string tag);
        int r0  = n_reads;
        int cyc = 0;
        @(negedge clk);
        cpu_addr = a; cpu_re = 1'b1; cpu_we = 4'b0000;
        @(negedge clk); #2;
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_miss});
        if (!exp_miss) check({tag, ".no_memreq"}, {31'd0, mem_req_valid}, 32'd0);
        while (stall && cyc < 50) begin
            @(negedge clk); #2;
            cyc++;
        end
        if (stall) check({tag, ".timeout"}, 32'd1, 32'd0);
        cpu_re = 1'b0;
        check({tag, ".dout"}, cpu_dout, exp);
        check({tag, ".refills"}, 32'(n_reads - r0), exp_miss ? 32'd1 : 32'd0);
        if (exp_miss) check({tag, ".refill_addr"}, last_raddr, a & ~32'hF);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [3:0] we,
                             input logic [31:0] din, input int hold, input string tag);
        int w0  = n_writes;
        int r0  = n_reads;
        int cyc = 0;
        bit stable = 1'b1;
        hold_cycles = hold;
        @(negedge clk);
        cpu_addr = a; cpu_re = 1'b0; cpu_we = we; cpu_din = din;
        @(negedge clk); #2;
        check({tag, ".valid"}, {31'd0, mem_req_valid}, 32'd1);
        check({tag, ".rnw"},   {31'd0, mem_req_rnw},   32'd0);
        check({tag, ".addr"},  mem_req_addr, a & ~32'h3);
        check({tag, ".wdata"}, mem_req_wdata, din);
        check({tag, ".wmask"}, {28'd0, mem_req_wmask}, {28'd0, we});
        while (stall && cyc < 50) begin
            if (!mem_req_valid || mem_req_rnw || mem_req_addr != (a & ~32'h3) ||
                mem_req_wdata != din || mem_req_wmask != we) stable = 1'b0;
            @(negedge clk); #2;
            cyc++;
        end
        cpu_we = 4'b0000;
        hold_cycles = 0;
        check({tag, ".stall_cycles"}, 32'(cyc), 32'(hold));
        check({tag, ".stable"}, {31'd0, stable}, 32'd1);
        check({tag, ".writes"}, 32'(n_writes - w0), 32'd1);
        check({tag, ".no_refill"}, 32'(n_reads - r0), 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; cpu_addr = 32'd0; cpu_re = 1'b0; cpu_we = 4'b0000; cpu_din = 32'd0;
        mem_rdata = 32'd0;
        bmem[32'h1000] = 32'h0000_0011;
        bmem[32'h1004] = 32'h0000_0022;
        bmem[32'h1008] = 32'h0000_0033;
        bmem[32'h100C] = 32'h0000_0044;
        repeat (3) @(negedge clk);
        #2;
        check("rst.stall", {31'd0, stall}, 32'd0);
        check("rst.valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst.rnw",   {31'd0, mem_req_rnw}, 32'd0);
        check("rst.addr",  mem_req_addr, 32'd0);
        check("rst.wdata", mem_req_wdata, 32'd0);
        check("rst.wmask", {28'd0, mem_req_wmask}, 32'd0);
        check("rst.dout",  cpu_dout, 32'd0);
        rst = 1'b0;

        cpu_read(32'h0000_1004, 32'h0000_0022, 1'b1, "rd_miss_1004");
        cpu_read(32'h0000_1008, 32'h0000_0033, 1'b0, "rd_hit_1008");
        cpu_write(32'h0000_1008, 4'b0011, 32'hAABB_CCDD, 0, "wr_hit_1008");
        cpu_read(32'h0000_1008, 32'h0000_CCDD, 1'b0, "rd_after_wr");
        cpu_write(32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 0, "wr_miss_2000");
        cpu_read(32'h0000_2000, 32'hDEAD_BEEF, 1'b1, "rd_miss_2000");
        cpu_read(32'h0000_1000, 32'h0000_0011, 1'b1, "conf_1000");
        cpu_read(32'h0000_1400, 32'h0000_1400, 1'b1, "conf_1400");
        cpu_read(32'h0000_1000, 32'h0000_0011, 1'b1, "conf_1000_again");
        cpu_read(32'h0000_100C, 32'h0000_0044, 1'b0, "hit_100C");
        cpu_write(32'h0000_1004, 4'b1111, 32'h1234_5678, 5, "wr_hold");
        cpu_read(32'h0000_1004, 32'h1234_5678, 1'b0, "rd_after_hold");

        // Reset arrives while beat 2 of a refill is on the bus.
        @(negedge clk);
        cpu_addr = 32'h0000_3000; cpu_re = 1'b1;
        cyc = 0;
        @(negedge clk); #2;
        while (beat_idx != 3 && cyc < 50) begin
            @(negedge clk); #2;
            cyc++;
        end
        check("rst_mid.reached_beat2", 32'(beat_idx), 32'd3);
        rst = 1'b1; cpu_re = 1'b0;
        @(posedge clk); #1;
        check("rst_mid.stall", {31'd0, stall}, 32'd0);
        check("rst_mid.valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_mid.dout",  cpu_dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cpu_read(32'h0000_3000, 32'h0000_3000, 1'b1, "rd_after_rst");
        cpu_read(32'h0000_300C, 32'h0000_300C, 1'b0, "hit_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
